alu_mc_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle register-file ALU.
- Operand width is generic, and the result is 2*DATA_WIDTH bits wide.
- Each accepted operation produces one ALU_OUT_VALID pulse.
- Division is an iterative restoring divider returning quotient and remainder, with divide-by-zero detection.
- Sits between the register file (REG0/REG1) and the system controller, in the ALU clock domain.

---
 rtl/alu_mc_pkg.sv | 37 +++
 rtl/alu_mc_div.sv | 88 ++++++++
 rtl/alu_mc_core.sv | 165 ++++++++++++++++
 tb/tb_alu_mc_core.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_pkg
//   Shared constants for the multi-cycle ALU core:
//     - ALU_FUNC operation codes (ALU_ADD .. ALU_RSVD)
//     - FSM state encoding (ST_IDLE, ST_DIV)
//     - result values returned by the compare operations
// -----------------------------------------------------------------------------
package alu_mc_pkg;

    // Operation codes presented on ALU_FUNC
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NAND = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_XNOR = 4'b1001;
    localparam logic [3:0] ALU_CMPEQ = 4'b1010;
    localparam logic [3:0] ALU_CMPGT = 4'b1011;
    localparam logic [3:0] ALU_CMPLT = 4'b1100;
    localparam logic [3:0] ALU_SHR  = 4'b1101;
    localparam logic [3:0] ALU_SHL  = 4'b1110;
    localparam logic [3:0] ALU_RSVD = 4'b1111;

    // Core FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DIV  = 1'b1;

    // Values returned by a true comparison
    localparam int CMP_EQ_VAL = 1;
    localparam int CMP_GT_VAL = 2;
    localparam int CMP_LT_VAL = 3;

endpackage

// File: rtl/alu_mc_div.sv
// -----------------------------------------------------------------------------
// alu_mc_div
//   Iterative restoring divider, one quotient bit per clock.
//   start loads the operands; DATA_WIDTH iterations follow on the next
//   DATA_WIDTH rising edges. done is high during the cycle before the final
//   iteration edge, and quotient/remainder then present the result of that
//   final iteration combinationally so the parent can register it on the
//   same edge the divider retires.
//
// Ports:
//   ALU_CLK     in   clock
//   RST_SYNC_2  in   async active-low reset
//   start       in   load operands and begin (only asserted while idle)
//   dividend    in   DATA_WIDTH
//   divisor     in   DATA_WIDTH, must be non-zero when start is asserted
//   busy        out  iterations outstanding
//   done        out  next edge performs the last iteration
//   quotient    out  DATA_WIDTH, valid while done
//   remainder   out  DATA_WIDTH, valid while done
// -----------------------------------------------------------------------------
module alu_mc_div #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  ALU_CLK,
    input  logic                  RST_SYNC_2,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] rem_r;   // partial remainder
    logic [DATA_WIDTH-1:0] quo_r;   // dividend bits shift out, quotient bits shift in
    logic [DATA_WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  qbit;

    // One restoring step. The partial remainder is always below the divisor,
    // so a W+1 bit difference is enough and its MSB is the borrow.
    always_comb begin
        shifted   = {rem_r, quo_r[DATA_WIDTH-1]};
        diff      = shifted - {1'b0, dvs_r};
        qbit      = ~diff[DATA_WIDTH];
        remainder = qbit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        quotient  = {quo_r[DATA_WIDTH-2:0], qbit};
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == LAST_ITER);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the datapath registers are reset as well as the control bits, so
    // an aborted division leaves no stale operands behind.
    always_ff @(posedge ALU_CLK or negedge RST_SYNC_2) begin
        if (!RST_SYNC_2) begin
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= '0;
            quo_r  <= dividend;
            dvs_r  <= divisor;
            cnt_r  <= '0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r <= remainder;
            quo_r <= quotient;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_ITER) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc_core.sv
// -----------------------------------------------------------------------------
// alu_mc_core
//   Multi-cycle register-file ALU. Every op except a non-zero divide completes
//   in one cycle; a non-zero divide runs on alu_mc_div for DATA_WIDTH cycles
//   while ALU_BUSY is high, and requests seen during that time are dropped.
//
// Optional feature: define ALU_MC_FLAGS_EN to add ALU_FLAGS = {N, C, Z}.
//
// Ports:
//   ALU_CLK        in   ALU domain clock
//   RST_SYNC_2     in   async active-low reset
//   ALU_EN         in   operation request
//   ALU_FUNC       in   [3:0] operation code (see alu_mc_pkg)
//   REG0, REG1     in   [DATA_WIDTH-1:0] operands A and B
//   ALU_BUSY       out  division in progress
//   ALU_OUT        out  [OUT_WIDTH-1:0] registered result
//   ALU_OUT_VALID  out  one-cycle pulse per completed operation
//   ALU_DIV_ERR    out  last result was a divide by zero
//   ALU_FLAGS      out  [2:0] {N, C, Z} (ALU_MC_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu_mc_core
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  ALU_CLK,
    input  logic                  RST_SYNC_2,
    input  logic                  ALU_EN,
    input  logic [3:0]            ALU_FUNC,
    input  logic [DATA_WIDTH-1:0] REG0,
    input  logic [DATA_WIDTH-1:0] REG1,
    output logic                  ALU_BUSY,
    output logic [OUT_WIDTH-1:0]  ALU_OUT,
    output logic                  ALU_OUT_VALID,
    output logic                  ALU_DIV_ERR
`ifdef ALU_MC_FLAGS_EN
    ,
    output logic [2:0]            ALU_FLAGS
`endif
);

    logic [0:0]            state;
    logic                  accept;
    logic                  div_start;

    logic                  div_busy;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quo;
    logic [DATA_WIDTH-1:0] div_rem;
    logic [OUT_WIDTH-1:0]  div_result;

    logic [OUT_WIDTH-1:0]  op_a;
    logic [OUT_WIDTH-1:0]  op_b;
    logic [OUT_WIDTH-1:0]  sc_result;
    logic                  sc_err;

    assign ALU_BUSY   = div_busy;
    assign accept     = ALU_EN && !ALU_BUSY;
    assign div_start  = accept && (ALU_FUNC == ALU_DIV) && (REG1 != '0);
    assign div_result = {div_rem, div_quo};

    // Operands are zero-extended before every op, which is why the inverting
    // logic ops return all ones in the upper half.
    assign op_a = {{(OUT_WIDTH - DATA_WIDTH){1'b0}}, REG0};
    assign op_b = {{(OUT_WIDTH - DATA_WIDTH){1'b0}}, REG1};

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        sc_result = '0;
        sc_err    = 1'b0;
        case (ALU_FUNC)
            ALU_ADD:  sc_result = op_a + op_b;
            ALU_SUB:  sc_result = op_a - op_b;
            ALU_MUL:  sc_result = op_a * op_b;
            // Only reaches the single-cycle path when REG1 is zero.
            ALU_DIV: begin
                sc_result = {REG0, {DATA_WIDTH{1'b1}}};
                sc_err    = 1'b1;
            end
            ALU_AND:   sc_result = op_a & op_b;
            ALU_OR:    sc_result = op_a | op_b;
            ALU_NAND:  sc_result = ~(op_a & op_b);
            ALU_NOR:   sc_result = ~(op_a | op_b);
            ALU_XOR:   sc_result = op_a ^ op_b;
            ALU_XNOR:  sc_result = ~(op_a ^ op_b);
            ALU_CMPEQ: sc_result = (REG0 == REG1) ? OUT_WIDTH'(CMP_EQ_VAL) : '0;
            ALU_CMPGT: sc_result = (REG0 >  REG1) ? OUT_WIDTH'(CMP_GT_VAL) : '0;
            ALU_CMPLT: sc_result = (REG0 <  REG1) ? OUT_WIDTH'(CMP_LT_VAL) : '0;
            ALU_SHR:   sc_result = op_a >> 1;
            ALU_SHL:   sc_result = op_a << 1;
            default:   sc_result = '0;
        endcase
    end

`ifdef ALU_MC_FLAGS_EN
    logic [2:0] sc_flags;

    always_comb begin
        sc_flags    = 3'b000;
        sc_flags[0] = (sc_result == '0);
        case (ALU_FUNC)
            ALU_ADD: begin
                sc_flags[1] = sc_result[DATA_WIDTH];
                sc_flags[2] = sc_result[DATA_WIDTH-1];
            end
            ALU_SUB: begin
                sc_flags[1] = (REG0 < REG1);
                sc_flags[2] = sc_result[DATA_WIDTH-1];
            end
            default: ;
        endcase
    end
`endif

    alu_mc_div #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div (
        .ALU_CLK    (ALU_CLK),
        .RST_SYNC_2 (RST_SYNC_2),
        .start      (div_start),
        .dividend   (REG0),
        .divisor    (REG1),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quo),
        .remainder  (div_rem)
    );

    always_ff @(posedge ALU_CLK or negedge RST_SYNC_2) begin
        if (!RST_SYNC_2) begin
            state         <= ST_IDLE;
            ALU_OUT       <= '0;
            ALU_OUT_VALID <= 1'b0;
            ALU_DIV_ERR   <= 1'b0;
`ifdef ALU_MC_FLAGS_EN
            ALU_FLAGS     <= 3'b000;
`endif
        end else begin
            ALU_OUT_VALID <= 1'b0;
            if (accept && !div_start) begin
                ALU_OUT       <= sc_result;
                ALU_DIV_ERR   <= sc_err;
                ALU_OUT_VALID <= 1'b1;
`ifdef ALU_MC_FLAGS_EN
                ALU_FLAGS     <= sc_flags;
`endif
            end else if ((state == ST_DIV) && div_done) begin
                // Final iteration lands in ALU_OUT on the divider's last edge.
                ALU_OUT       <= div_result;
                ALU_DIV_ERR   <= 1'b0;
                ALU_OUT_VALID <= 1'b1;
                state         <= ST_IDLE;
`ifdef ALU_MC_FLAGS_EN
                ALU_FLAGS     <= {2'b00, (div_result == '0)};
`endif
            end
            if (div_start) begin
                state <= ST_DIV;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc_core.sv
// -----------------------------------------------------------------------------
// tb_alu_mc_core
//   Bench for alu_mc_core at DATA_WIDTH=8. A behavioural model built from the
//   arithmetic definition of each op predicts the outputs every cycle; a set of
//   hand-computed values pins the model for the directed scenarios, followed by
//   a randomized run. Define ALU_MC_FLAGS_EN to also cover ALU_FLAGS.
// -----------------------------------------------------------------------------
module tb_alu_mc_core;

    localparam int W  = 8;
    localparam int OW = 16;

    logic          ALU_CLK    = 1'b0;
    logic          RST_SYNC_2 = 1'b0;
    logic          ALU_EN     = 1'b0;
    logic [3:0]    ALU_FUNC   = 4'h0;
    logic [W-1:0]  REG0       = '0;
    logic [W-1:0]  REG1       = '0;
    logic          ALU_BUSY;
    logic [OW-1:0] ALU_OUT;
    logic          ALU_OUT_VALID;
    logic          ALU_DIV_ERR;
`ifdef ALU_MC_FLAGS_EN
    logic [2:0]    ALU_FLAGS;
`endif

    alu_mc_core #(
        .DATA_WIDTH (W)
    ) dut (
        .ALU_CLK       (ALU_CLK),
        .RST_SYNC_2    (RST_SYNC_2),
        .ALU_EN        (ALU_EN),
        .ALU_FUNC      (ALU_FUNC),
        .REG0          (REG0),
        .REG1          (REG1),
        .ALU_BUSY      (ALU_BUSY),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .ALU_DIV_ERR   (ALU_DIV_ERR)
`ifdef ALU_MC_FLAGS_EN
        ,
        .ALU_FLAGS     (ALU_FLAGS)
`endif
    );

    always #5 ALU_CLK = ~ALU_CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Returns {N, C, Z, div_err, result[15:0]} for a single-cycle op.
    function automatic logic [19:0] ref_op(input logic [3:0] f, input int a, input int b);
        int   v;
        logic c;
        logic n;
        logic e;
        v = 0;
        c = 1'b0;
        e = 1'b0;
        case (f)
            4'h0: begin v = a + b; c = (v > 255); end
            4'h1: begin v = (a - b) & 'hFFFF; c = (a < b); end
            4'h2: v = a * b;
            4'h3: begin v = (a * 256) + 255; e = 1'b1; end
            4'h4: v = a & b;
            4'h5: v = a | b;
            4'h6: v = (~(a & b)) & 'hFFFF;
            4'h7: v = (~(a | b)) & 'hFFFF;
            4'h8: v = a ^ b;
            4'h9: v = (~(a ^ b)) & 'hFFFF;
            4'hA: v = (a == b) ? 1 : 0;
            4'hB: v = (a > b) ? 2 : 0;
            4'hC: v = (a < b) ? 3 : 0;
            4'hD: v = a / 2;
            4'hE: v = a * 2;
            default: v = 0;
        endcase
        n = (f <= 4'h1) ? v[7] : 1'b0;
        return {n, c, (v == 0), e, v[15:0]};
    endfunction

    int          m_left  = 0;      // division cycles still outstanding
    logic [15:0] m_pend  = '0;
    logic [15:0] m_out   = '0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [2:0]  m_flags = '0;

    always @(posedge ALU_CLK or negedge RST_SYNC_2) begin
        if (!RST_SYNC_2) begin
            m_left  <= 0;
            m_pend  <= '0;
            m_out   <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_flags <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_out   <= m_pend;
                m_err   <= 1'b0;
                m_valid <= 1'b1;
                m_flags <= {2'b00, (m_pend == 16'h0)};
            end else begin
                m_valid <= 1'b0;
            end
        end else if (ALU_EN) begin
            if (ALU_FUNC == 4'h3 && REG1 != 0) begin
                m_pend  <= {REG0 % REG1, REG0 / REG1};
                m_left  <= W;
                m_valid <= 1'b0;
            end else begin
                {m_flags, m_err, m_out} <= ref_op(ALU_FUNC, REG0, REG1);
                m_valid <= 1'b1;
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

    // Compare process: every cycle out of reset
    always @(negedge ALU_CLK) begin
        if (RST_SYNC_2) begin
            check("cyc_busy",  ALU_BUSY,      m_left != 0);
            check("cyc_valid", ALU_OUT_VALID, m_valid);
            check("cyc_out",   ALU_OUT,       m_out);
            check("cyc_err",   ALU_DIV_ERR,   m_err);
`ifdef ALU_MC_FLAGS_EN
            check("cyc_flags", ALU_FLAGS,     m_flags);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        ALU_EN   = 1'b1;
        ALU_FUNC = f;
        REG0     = a;
        REG1     = b;
    endtask

    task automatic lit(input string name, input logic [15:0] exp_out, input logic exp_err);
        check({name, "_out"},   ALU_OUT,       exp_out);
        check({name, "_valid"}, ALU_OUT_VALID, 1'b1);
        check({name, "_err"},   ALU_DIV_ERR,   exp_err);
    endtask

    logic [3:0]  t5_f   [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [7:0]  t5_a   [6] = '{8'd9, 8'd9, 8'd9, 8'h81, 8'h81, 8'h12};
    logic [7:0]  t5_b   [6] = '{8'd9, 8'd4, 8'd4, 8'h00, 8'h00, 8'h34};
    logic [15:0] t5_exp [6] = '{16'h0001, 16'h0002, 16'h0000, 16'h0040, 16'h0102, 16'h0000};

    initial begin
        int busy_cnt;
        int vcnt;
        bit seen;

        // Reset values
        repeat (3) @(negedge ALU_CLK);
        check("rst_out",   ALU_OUT,       16'h0);
        check("rst_valid", ALU_OUT_VALID, 1'b0);
        check("rst_busy",  ALU_BUSY,      1'b0);
        check("rst_err",   ALU_DIV_ERR,   1'b0);
        RST_SYNC_2 = 1'b1;
        @(negedge ALU_CLK);

        // Arithmetic sweep, back to back
        drive(4'h0, 8'hFF, 8'h01); @(negedge ALU_CLK); lit("add", 16'h0100, 1'b0);
        drive(4'h1, 8'd3,  8'd5);  @(negedge ALU_CLK); lit("sub", 16'hFFFE, 1'b0);
        drive(4'h2, 8'hFF, 8'hFF); @(negedge ALU_CLK); lit("mul", 16'hFE01, 1'b0);
        ALU_EN = 1'b0;
        @(negedge ALU_CLK);
        check("pulse_len", ALU_OUT_VALID, 1'b0);

        // Division 200/7 with an ignored request while busy
        drive(4'h3, 8'd200, 8'd7);
        @(negedge ALU_CLK);
        ALU_EN   = 1'b0;
        busy_cnt = 0;
        seen     = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ALU_BUSY) busy_cnt++;
            if (ALU_OUT_VALID) begin
                seen = 1;
                lit("div", 16'h041C, 1'b0);
            end else begin
                if (i == 2) drive(4'h0, 8'd1, 8'd1);
                if (i == 3) ALU_EN = 1'b0;
                @(negedge ALU_CLK);
            end
        end
        ALU_EN = 1'b0;
        check("div_done_seen",   seen,     1'b1);
        check("div_busy_cycles", busy_cnt, 8);
        @(negedge ALU_CLK);
        check("div_single_pulse", ALU_OUT_VALID, 1'b0);

        // Divide by zero, then a normal op clears the error
        drive(4'h3, 8'h5A, 8'h00); @(negedge ALU_CLK); lit("div0", 16'h5AFF, 1'b1);
        drive(4'h4, 8'hF0, 8'h3C); @(negedge ALU_CLK); lit("and",  16'h0030, 1'b0);
        ALU_EN = 1'b0;
        @(negedge ALU_CLK);

        // Compare, shift and reserved, continuous ALU_EN
        for (int i = 0; i < 6; i++) begin
            drive(t5_f[i], t5_a[i], t5_b[i]);
            @(negedge ALU_CLK);
            lit($sformatf("t5_%0d", i), t5_exp[i], 1'b0);
        end
        ALU_EN = 1'b0;
        @(negedge ALU_CLK);

`ifdef ALU_MC_FLAGS_EN
        drive(4'h1, 8'd5, 8'd5); @(negedge ALU_CLK);
        check("flags_zero", ALU_FLAGS, 3'b001);
        drive(4'h1, 8'd3, 8'd5); @(negedge ALU_CLK);
        check("flags_borrow", ALU_FLAGS, 3'b110);
        ALU_EN = 1'b0;
        @(negedge ALU_CLK);
`endif

        // Reset asserted in the middle of a division
        drive(4'h3, 8'd200, 8'd7);
        @(negedge ALU_CLK);
        ALU_EN = 1'b0;
        repeat (3) @(posedge ALU_CLK);
        #2 RST_SYNC_2 = 1'b0;
        #1;
        check("abort_out",   ALU_OUT,       16'h0);
        check("abort_valid", ALU_OUT_VALID, 1'b0);
        check("abort_busy",  ALU_BUSY,      1'b0);
        check("abort_err",   ALU_DIV_ERR,   1'b0);
        repeat (2) @(negedge ALU_CLK);
        RST_SYNC_2 = 1'b1;
        vcnt = 0;
        repeat (12) begin
            @(negedge ALU_CLK);
            if (ALU_OUT_VALID) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        drive(4'h0, 8'd2, 8'd3); @(negedge ALU_CLK); lit("post_rst_add", 16'h0005, 1'b0);
        ALU_EN = 1'b0;
        @(negedge ALU_CLK);

        // Randomized run against the model
        repeat (600) begin
            if ($urandom_range(9) < 7) begin
                drive(4'($urandom_range(15)), 8'($urandom),
                      ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom));
            end else begin
                ALU_EN = 1'b0;
                REG0   = 8'($urandom);
                REG1   = 8'($urandom);
            end
            @(negedge ALU_CLK);
        end
        ALU_EN = 1'b0;
        repeat (12) @(negedge ALU_CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
